// File: rtl/lsu_mem_port.sv
// Load/store port: one request in flight, sizes and aligns it onto a 32-bit word memory bus.
// Latency: accept + N wait cycles + 1 resp cycle (errors respond the cycle after accept); req_ready only in IDLE.
module lsu_mem_port #(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_byte_enable,
   input  logic [31:0] mem_rdata,
   input  logic        mem_resp
);

   typedef enum logic [1:0] {IDLE, MEM_WAIT, RESP} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t      state;
   logic [7:0]  wait_cnt;
   logic [2:0]  lat_funct3;
   logic [1:0]  lat_off;

   logic        illegal;
   logic        misaligned;
   logic [3:0]  be;
   logic [31:0] wdata_sh;
   logic [31:0] rdata_sh;
   logic [31:0] load_data;

   assign req_ready = (state == IDLE);

   always_comb begin
      illegal    = req_store ? (req_funct3 >= 3'd3)
                             : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
      misaligned = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                   (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'b00);
      be = 4'b1111;
      if (req_store) begin
         case (req_funct3[1:0])
            2'd0:    be = 4'b0001 << req_addr[1:0];
            2'd1:    be = 4'b0011 << req_addr[1:0];
            default: be = 4'b1111;
         endcase
      end
      wdata_sh = req_wdata << {req_addr[1:0], 3'b000};
   end

   // Extraction uses the offset/width latched at accept, not the live request.
   always_comb begin
      rdata_sh = mem_rdata >> {lat_off, 3'b000};
      case (lat_funct3)
         3'd0:    load_data = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
         3'd1:    load_data = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
         3'd4:    load_data = {24'd0, rdata_sh[7:0]};
         3'd5:    load_data = {16'd0, rdata_sh[15:0]};
         default: load_data = rdata_sh;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         wait_cnt        <= 8'd0;
         lat_funct3      <= 3'd0;
         lat_off         <= 2'd0;
         resp_valid      <= 1'b0;
         resp_rdata      <= 32'd0;
         resp_err        <= 2'd0;
         mem_read        <= 1'b0;
         mem_write       <= 1'b0;
         mem_address     <= 32'd0;
         mem_wdata       <= 32'd0;
         mem_byte_enable <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_funct3      <= req_funct3;
                  lat_off         <= req_addr[1:0];
                  mem_address     <= {req_addr[31:2], 2'b00};
                  mem_wdata       <= wdata_sh;
                  mem_byte_enable <= be;
                  wait_cnt        <= 8'd0;
                  resp_rdata      <= 32'd0;
                  if (illegal) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 2'd2;
                  end else if (misaligned) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 2'd1;
                  end else begin
                     state     <= MEM_WAIT;
                     mem_read  <= ~req_store;
                     mem_write <= req_store;
                  end
               end
            end
            MEM_WAIT: begin
               // A response in the final permitted cycle beats the timeout.
               if (mem_resp) begin
                  state      <= RESP;
                  mem_read   <= 1'b0;
                  mem_write  <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 2'd0;
                  resp_rdata <= mem_write ? 32'd0 : load_data;
               end else if (wait_cnt == WAIT_LAST) begin
                  state      <= RESP;
                  mem_read   <= 1'b0;
                  mem_write  <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 2'd3;
                  resp_rdata <= 32'd0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            RESP: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               resp_rdata <= 32'd0;
               resp_err   <= 2'd0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: scoreboard of expected responses, strobe/lane checks per access.
module tb_lsu_mem_port;

   localparam int MAXW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_rdata;
   logic        mem_resp;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  err;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   lsu_mem_port #(.MAX_WAIT(MAXW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Responses are compared in order against the scoreboard away from the active edge.
   always @(negedge clk) begin
      if (resp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("spurious_resp", 32'(resp_valid), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", 32'(resp_err), 32'(e.err));
         end
      end
   end

   // wait_n: cycle of MEM_WAIT on which mem_resp is given (0 = never, expect timeout).
   task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int wait_n, input logic [31:0] mrd,
                         input logic [31:0] exp_rd, input logic [1:0] exp_err,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd);
      exp_t e;
      logic [1:0] strobe;
      bit legal;
      legal  = (exp_err == 2'd0 || exp_err == 2'd3);
      strobe = st ? 2'b01 : 2'b10;
      chk("ready_idle", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      e.rdata = exp_rd;
      e.err   = exp_err;
      exp_q.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (legal) begin
         for (int i = 1; i <= MAXW; i++) begin
            chk("strobe_wait", 32'({mem_read, mem_write}), 32'(strobe));
            chk("mem_address", mem_address, {addr[31:2], 2'b00});
            chk("byte_enable", 32'(mem_byte_enable), 32'(exp_be));
            chk("mem_wdata", mem_wdata, exp_wd);
            chk("ready_busy", 32'(req_ready), 32'd0);
            chk("no_early_resp", 32'(resp_valid), 32'd0);
            if (i == wait_n) begin
               mem_resp  = 1'b1;
               mem_rdata = mrd;
            end
            @(posedge clk); #1;
            mem_resp  = 1'b0;
            mem_rdata = 32'hDEAD_0000;
            if (i == wait_n) break;
         end
      end else begin
         chk("no_strobe_err", 32'({mem_read, mem_write}), 32'd0);
      end
      chk("resp_pulse", 32'(resp_valid), 32'd1);
      chk("strobe_dropped", 32'({mem_read, mem_write}), 32'd0);
      chk("ready_resp", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      chk("resp_one_cycle", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0; mem_rdata = 32'd0; mem_resp = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_err", 32'(resp_err), 32'd0);
      chk("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
      chk("rst_addr", mem_address, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_be", 32'(mem_byte_enable), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Stray mem_resp in IDLE must do nothing.
      mem_resp = 1'b1;
      @(posedge clk); #1;
      mem_resp = 1'b0;
      chk("stray_resp_ready", 32'(req_ready), 32'd1);
      chk("stray_resp_strobe", 32'({mem_read, mem_write}), 32'd0);

      // lb: accept + 2 waits -> resp_valid in 4th cycle counting accept as 1st
      access(0, 3'd0, 32'h0000_1003, 32'd0, 2, 32'h80FF_1234, 32'hFFFF_FF80, 2'd0, 4'b1111, 32'd0);
      access(1, 3'd1, 32'h0000_2002, 32'h0000_ABCD, 3, 32'd0, 32'd0, 2'd0, 4'b1100, 32'hABCD_0000);
      access(0, 3'd2, 32'h0000_3001, 32'd0, 0, 32'd0, 32'd0, 2'd1, 4'b1111, 32'd0);
      access(1, 3'd5, 32'h0000_3000, 32'h1234_5678, 0, 32'd0, 32'd0, 2'd2, 4'b1111, 32'd0);
      access(0, 3'd3, 32'h0000_3001, 32'd0, 0, 32'd0, 32'd0, 2'd2, 4'b1111, 32'd0);
      access(0, 3'd5, 32'h0000_4002, 32'd0, 0, 32'h8765_4321, 32'd0, 2'd3, 4'b1111, 32'd0);
      access(0, 3'd5, 32'h0000_4002, 32'd0, 4, 32'h8765_4321, 32'h0000_8765, 2'd0, 4'b1111, 32'd0);
      access(0, 3'd1, 32'h0000_5002, 32'd0, 1, 32'h8765_4321, 32'hFFFF_8765, 2'd0, 4'b1111, 32'd0);
      access(0, 3'd4, 32'h0000_6000, 32'd0, 1, 32'h1234_56F0, 32'h0000_00F0, 2'd0, 4'b1111, 32'd0);
      access(1, 3'd0, 32'h0000_7003, 32'h0000_00A5, 2, 32'd0, 32'd0, 2'd0, 4'b1000, 32'hA500_0000);
      access(0, 3'd2, 32'h0000_8000, 32'd0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'd0, 4'b1111, 32'd0);
      access(0, 3'd1, 32'h0000_9001, 32'd0, 0, 32'd0, 32'd0, 2'd1, 4'b1111, 32'd0);

      // Reset while waiting on memory: strobe drops, late mem_resp is ignored.
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_A000;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rstwait_strobe_on", 32'(mem_read), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rstwait_strobe_off", 32'({mem_read, mem_write}), 32'd0);
      chk("rstwait_ready", 32'(req_ready), 32'd1);
      chk("rstwait_no_resp", 32'(resp_valid), 32'd0);
      mem_resp = 1'b1; mem_rdata = 32'h1111_2222;
      @(posedge clk); #1;
      mem_resp = 1'b0;
      chk("late_resp_ignored", 32'(resp_valid), 32'd0);
      chk("late_resp_ready", 32'(req_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
